gate_op_arbiter: RTL and testbench

//  Shares one registered bitwise logic unit (AND/OR/XOR/NAND) among N_REQ requesters.

---
 rtl/gate_op_arbiter.sv | 168 ++++++++++++++++
 tb/tb_gate_op_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_op_arbiter.sv
// gate_op_arbiter: round-robin arbiter that shares one registered AND/OR/XOR/NAND unit among N_REQ requesters.
// Optional feature: define GATE_ARB_PERF_EN to add the perf_busy saturating busy-cycle counter port.
module gate_op_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [N_REQ-1:0]                             req_valid,
  output logic [N_REQ-1:0]                             req_ready,
  input  logic [N_REQ*WIDTH-1:0]                       req_a,
  input  logic [N_REQ*WIDTH-1:0]                       req_b,
  input  logic [N_REQ*2-1:0]                           req_op,
  output logic                                         rsp_valid,
  input  logic                                         rsp_ready,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] rsp_id,
`ifdef GATE_ARB_PERF_EN
  output logic [31:0]                                  perf_busy,
`endif
  output logic [WIDTH-1:0]                             rsp_data
);

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  function automatic logic [WIDTH-1:0] gate_eval(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [1:0]       op);
    case (op)
      2'b00:   gate_eval = a & b;
      2'b01:   gate_eval = a | b;
      2'b10:   gate_eval = a ^ b;
      default: gate_eval = ~(a & b);
    endcase
  endfunction

  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] idx);
    wrap_inc = (idx == ID_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
  endfunction

`ifdef GATE_ARB_PERF_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    sat_inc32 = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction
`endif

  logic [1:0]       state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic [WIDTH-1:0] a_q, b_q;
  logic [1:0]       op_q;
  logic [ID_W-1:0]  win_q;

  logic [N_REQ-1:0] rot_valid;
  logic             win_found;
  logic [ID_W-1:0]  win_off;
  logic [ID_W:0]    win_sum;
  logic [ID_W-1:0]  win_idx;
  logic             grant_en;
  logic [WIDTH-1:0] a_sel, b_sel;
  logic [1:0]       op_sel;

  // Arbitration: rotate valids so bit 0 is rr_ptr, pick the lowest set bit, then map back.
  assign rot_valid = N_REQ'({req_valid, req_valid} >> rr_ptr_q);
  assign win_found = |rot_valid;

  always_comb begin
    win_off = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot_valid[k]) win_off = ID_W'(k);
    end
    win_sum = {1'b0, rr_ptr_q} + {1'b0, win_off};
    if (win_sum >= (ID_W + 1)'(N_REQ)) win_idx = ID_W'(win_sum - (ID_W + 1)'(N_REQ));
    else                               win_idx = win_sum[ID_W-1:0];
  end

  assign grant_en  = (state_q == S_IDLE) && !rst && win_found;
  assign req_ready = grant_en ? (N_REQ'(1) << win_idx) : '0;

  always_comb begin
    a_sel  = '0;
    b_sel  = '0;
    op_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == ID_W'(i)) begin
        a_sel  = req_a[i*WIDTH +: WIDTH];
        b_sel  = req_b[i*WIDTH +: WIDTH];
        op_sel = req_op[i*2 +: 2];
      end
    end
  end

  // Capture stage: operands of the granted requester, loaded only on the accept edge.
  always_ff @(posedge clk) begin
    if (grant_en) begin
      a_q   <= a_sel;
      b_q   <= b_sel;
      op_q  <= op_sel;
      win_q <= win_idx;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) state_d = S_EXEC;
      end
      S_EXEC: begin
        rsp_data_d  = gate_eval(a_q, b_q, op_q);
        rsp_id_d    = win_q;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rr_ptr_d    = wrap_inc(rsp_id_q);
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Execute/response stage: result registers change only on EXEC->RESP or reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

`ifdef GATE_ARB_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk) begin
    if (rst)                    perf_q <= '0;
    else if (state_q != S_IDLE) perf_q <= sat_inc32(perf_q);
  end

  assign perf_busy = perf_q;
`endif

endmodule

// File: tb/tb_gate_op_arbiter.sv
// Self-checking bench for gate_op_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_gate_op_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic [2*N-1:0] req_op;
  logic           rsp_valid, rsp_ready;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_data;
`ifdef GATE_ARB_PERF_EN
  logic [31:0]    perf_busy;
`endif

  int passed = 0;
  int total  = 0;

  gate_op_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
`ifdef GATE_ARB_PERF_EN
    .perf_busy (perf_busy),
`endif
    .rsp_data  (rsp_data)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] gate_ref(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  function automatic int exp_winner(input int rr, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (((v >> ((rr + k) % N)) & N'(1)) != '0) return (rr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] exp_result(input int w);
    return gate_ref(W'(req_a >> (w * W)), W'(req_b >> (w * W)), 2'(req_op >> (2 * w)));
  endfunction

  task automatic cyc(input logic r, input logic [N-1:0] v, input logic rdy);
    @(negedge clk);
    rst = r; req_valid = v; rsp_ready = rdy;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '1; rsp_ready = 1'b1;
    req_a = $urandom; req_b = $urandom; req_op = 8'($urandom);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      total++; if (req_ready !== 4'b0000) $display("FAIL reset_req_ready c%0d: got %b want 0000", c, req_ready); else passed++;
      total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid c%0d: got %b want 0", c, rsp_valid); else passed++;
      total++; if (rsp_data !== 8'h00) $display("FAIL reset_rsp_data c%0d: got %h want 00", c, rsp_data); else passed++;
      total++; if (rsp_id !== 2'd0) $display("FAIL reset_rsp_id c%0d: got %0d want 0", c, rsp_id); else passed++;
    end
  endtask

  task automatic test_ops();
    logic [W-1:0] exp_tab [4] = '{8'h30, 8'hFC, 8'hCC, 8'hCF};
    req_a[7:0] = 8'hF0; req_b[7:0] = 8'h3C;
    for (int i = 0; i < 4; i++) begin
      req_op[1:0] = 2'(i);
      cyc(1'b0, 4'b0001, 1'b1);
      total++; if ({req_ready, rsp_valid} !== 5'b0001_0) $display("FAIL ops_grant op%0d: ready=%b valid=%b want 0001/0", i, req_ready, rsp_valid); else passed++;
      cyc(1'b0, 4'b0001, 1'b1);
      total++; if ({req_ready, rsp_valid} !== 5'b0000_0) $display("FAIL ops_exec op%0d: ready=%b valid=%b want 0000/0", i, req_ready, rsp_valid); else passed++;
      cyc(1'b0, 4'b0001, 1'b1);
      total++; if (rsp_valid !== 1'b1) $display("FAIL ops_rsp_valid op%0d: got %b want 1", i, rsp_valid); else passed++;
      total++; if (rsp_data !== exp_tab[i]) $display("FAIL ops_rsp_data op%0d: got %h want %h", i, rsp_data, exp_tab[i]); else passed++;
      total++; if ({rsp_id, req_ready} !== 6'b00_0000) $display("FAIL ops_rsp_id op%0d: id=%0d ready=%b want 0/0000", i, rsp_id, req_ready); else passed++;
    end
  endtask

  task automatic test_round_robin();
    int rr = 0;
    int w;
    logic [W-1:0] ed;
    do_reset();
    for (int n = 0; n < 5; n++) begin
      req_a = $urandom; req_b = $urandom; req_op = 8'($urandom);
      w  = exp_winner(rr, 4'b1111);
      ed = exp_result(w);
      cyc(1'b0, 4'b1111, 1'b1);
      total++; if (req_ready !== (4'(1) << w)) $display("FAIL rr_grant n%0d: got %b want %b", n, req_ready, 4'(1) << w); else passed++;
      cyc(1'b0, 4'b1111, 1'b1);
      total++; if ({req_ready, rsp_valid} !== 5'b0000_0) $display("FAIL rr_exec n%0d: ready=%b valid=%b want 0000/0", n, req_ready, rsp_valid); else passed++;
      cyc(1'b0, 4'b1111, 1'b1);
      total++; if ({rsp_valid, rsp_id} !== {1'b1, 2'(w)}) $display("FAIL rr_rsp_id n%0d: valid=%b id=%0d want 1/%0d", n, rsp_valid, rsp_id, w); else passed++;
      total++; if (rsp_data !== ed) $display("FAIL rr_rsp_data n%0d: got %h want %h", n, rsp_data, ed); else passed++;
      rr = (w + 1) % N;
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] ed;
    do_reset();
    req_a[23:16] = 8'($urandom); req_b[23:16] = 8'($urandom); req_op[5:4] = 2'($urandom);
    ed = gate_ref(req_a[23:16], req_b[23:16], req_op[5:4]);
    cyc(1'b0, 4'b0100, 1'b0);
    total++; if (req_ready !== 4'b0100) $display("FAIL bp_grant: got %b want 0100", req_ready); else passed++;
    cyc(1'b0, 4'b0100, 1'b0);
    total++; if ({req_ready, rsp_valid} !== 5'b0000_0) $display("FAIL bp_exec: ready=%b valid=%b want 0000/0", req_ready, rsp_valid); else passed++;
    for (int c = 0; c < 6; c++) begin
      cyc(1'b0, 4'b0100, (c == 5));
      total++; if ({rsp_valid, rsp_id, req_ready} !== 7'b1_10_0000) $display("FAIL bp_hold c%0d: valid=%b id=%0d ready=%b want 1/2/0000", c, rsp_valid, rsp_id, req_ready); else passed++;
      total++; if (rsp_data !== ed) $display("FAIL bp_hold_data c%0d: got %h want %h", c, rsp_data, ed); else passed++;
    end
    cyc(1'b0, 4'b0100, 1'b1);
    total++; if ({rsp_valid, req_ready} !== 5'b0_0100) $display("FAIL bp_release: valid=%b ready=%b want 0/0100", rsp_valid, req_ready); else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_a[15:8] = 8'hAA; req_b[15:8] = 8'h55; req_op[3:2] = 2'b01;
    req_a[31:24] = 8'hFF; req_b[31:24] = 8'h0F; req_op[7:6] = 2'b01;
    cyc(1'b0, 4'b0010, 1'b1);
    total++; if (req_ready !== 4'b0010) $display("FAIL rm_grant1: got %b want 0010", req_ready); else passed++;
    cyc(1'b0, 4'b0000, 1'b1);
    cyc(1'b0, 4'b0000, 1'b1);
    total++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd1, 8'hFF}) $display("FAIL rm_rsp1: valid=%b id=%0d data=%h want 1/1/ff", rsp_valid, rsp_id, rsp_data); else passed++;
    cyc(1'b0, 4'b1000, 1'b1);
    total++; if (req_ready !== 4'b1000) $display("FAIL rm_grant3: got %b want 1000", req_ready); else passed++;
    cyc(1'b1, 4'b0000, 1'b1);
    cyc(1'b0, 4'b1111, 1'b1);
    total++; if ({rsp_valid, rsp_id, rsp_data} !== 11'b0_00_00000000) $display("FAIL rm_exec_reset: valid=%b id=%0d data=%h want 0/0/00", rsp_valid, rsp_id, rsp_data); else passed++;
    total++; if (req_ready !== 4'b0001) $display("FAIL rm_exec_restart: got %b want 0001", req_ready); else passed++;
    cyc(1'b0, 4'b0000, 1'b1);
    total++; if (rsp_valid !== 1'b0) $display("FAIL rm_exec_norsp: got %b want 0", rsp_valid); else passed++;
    cyc(1'b0, 4'b0000, 1'b1);
    cyc(1'b0, 4'b1000, 1'b0);
    total++; if (req_ready !== 4'b1000) $display("FAIL rm_grant3b: got %b want 1000", req_ready); else passed++;
    cyc(1'b0, 4'b0000, 1'b0);
    cyc(1'b0, 4'b0000, 1'b0);
    total++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd3, 8'hFF}) $display("FAIL rm_rsp3: valid=%b id=%0d data=%h want 1/3/ff", rsp_valid, rsp_id, rsp_data); else passed++;
    cyc(1'b1, 4'b0000, 1'b0);
    cyc(1'b0, 4'b1111, 1'b1);
    total++; if ({rsp_valid, rsp_id, rsp_data} !== 11'b0_00_00000000) $display("FAIL rm_resp_reset: valid=%b id=%0d data=%h want 0/0/00", rsp_valid, rsp_id, rsp_data); else passed++;
    total++; if (req_ready !== 4'b0001) $display("FAIL rm_resp_restart: got %b want 0001", req_ready); else passed++;
  endtask

`ifdef GATE_ARB_PERF_EN
  task automatic test_perf();
    do_reset();
    cyc(1'b0, 4'b0001, 1'b1);
    total++; if (perf_busy !== 32'd0) $display("FAIL perf_start: got %0d want 0", perf_busy); else passed++;
    repeat (8) cyc(1'b0, 4'b0001, 1'b1);
    cyc(1'b0, 4'b0000, 1'b1);
    total++; if (perf_busy !== 32'd6) $display("FAIL perf_count: got %0d want 6", perf_busy); else passed++;
    cyc(1'b0, 4'b0000, 1'b1);
    total++; if (perf_busy !== 32'd6) $display("FAIL perf_idle: got %0d want 6", perf_busy); else passed++;
  endtask
`endif

  task automatic test_random();
    int rr = 0;
    int age = 0;
    int w;
    int exp_id = 0;
    bit busy = 1'b0;
    logic [W-1:0] exp_data = '0;
    logic [N-1:0] exp_rdy;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      rst       = 1'b0;
      req_valid = ($urandom_range(0, 4) == 0) ? '0 : N'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      req_a = $urandom; req_b = $urandom; req_op = 8'($urandom);
      #1;
      if (!busy) begin
        w       = exp_winner(rr, req_valid);
        exp_rdy = (w >= 0) ? (4'(1) << w) : 4'b0000;
        total++; if (req_ready !== exp_rdy) $display("FAIL rand_grant c%0d: got %b want %b (valid %b rr %0d)", c, req_ready, exp_rdy, req_valid, rr); else passed++;
        total++; if (rsp_valid !== 1'b0) $display("FAIL rand_idle_valid c%0d: got %b want 0", c, rsp_valid); else passed++;
        if (w >= 0) begin
          busy = 1'b1; age = 0; exp_id = w; exp_data = exp_result(w);
        end
      end else begin
        age++;
        total++; if (req_ready !== 4'b0000) $display("FAIL rand_busy_ready c%0d: got %b want 0000", c, req_ready); else passed++;
        total++; if (rsp_valid !== (age >= 2)) $display("FAIL rand_rsp_valid c%0d: got %b want %b", c, rsp_valid, (age >= 2)); else passed++;
        if (age >= 2) begin
          total++; if ({rsp_id, rsp_data} !== {2'(exp_id), exp_data}) $display("FAIL rand_rsp c%0d: id=%0d data=%h want %0d/%h", c, rsp_id, rsp_data, exp_id, exp_data); else passed++;
          if (rsp_ready) begin
            busy = 1'b0;
            rr   = (exp_id + 1) % N;
          end
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ops();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
`ifdef GATE_ARB_PERF_EN
    test_perf();
`endif
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
